// File: rtl/ws2812_pkg.sv
// Shared command encoding, pixel field offsets and sequencer states for the WS2812 path.
// Combinational definitions only; no latency or backpressure of its own.
package ws2812_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_SEND  = 2'b01,
    CMD_LATCH = 2'b10
  } cmd_e;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_LATCH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ws2812_scale.sv
// Brightness scaler: out = (ch * (bright + 1)) >> 8; purely combinational, no flow control.
// bright=255 passes ch through unchanged, bright=0 always yields zero.
module ws2812_scale (
  input  logic [7:0] ch,
  input  logic [7:0] bright,
  output logic [7:0] out
);

  logic [8:0]  factor;
  logic [15:0] prod;

  // Largest product is 255*256 = 65280, so bit 16 of the wider product is never set.
  assign factor = {1'b0, bright} + 9'd1;
  assign prod   = {8'd0, ch} * {7'd0, factor};
  assign out    = prod[15:8];

endmodule

// File: rtl/ws2812_strip_scheduler.sv
// Frame sequencer: fetches each pixel (1-cycle RAM), scales it and presents it to the strip controller.
// New r/g/b are stable 2 cycles after a cmd_req; the controller paces the frame via cmd_req pulses.
module ws2812_strip_scheduler
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = ($clog2(NUM_LEDS) > 0) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_rf,
  input  logic [7:0]        bright,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd,
  input  logic [23:0]       pix_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [1:0]        cmd,
  input  logic              cmd_req,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);

  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        bright_q;
  logic [7:0]        sc_r;
  logic [7:0]        sc_g;
  logic [7:0]        sc_b;

  ws2812_scale u_scale_r (.ch(pix_data[R_LSB +: 8]), .bright(bright_q), .out(sc_r));
  ws2812_scale u_scale_g (.ch(pix_data[G_LSB +: 8]), .bright(bright_q), .out(sc_g));
  ws2812_scale u_scale_b (.ch(pix_data[B_LSB +: 8]), .bright(bright_q), .out(sc_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      bright_q   <= '0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      cmd        <= CMD_IDLE;
      pix_addr   <= '0;
      pix_rd     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_rd     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // cmd_req is ignored here, so start always wins a same-cycle collision.
          if (start) begin
            bright_q <= bright;
            idx      <= '0;
            pix_addr <= '0;
            pix_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          r     <= sc_r;
          g     <= sc_g;
          b     <= sc_b;
          cmd   <= CMD_SEND;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (cmd_req) begin
            if (idx == LAST) begin
              cmd   <= CMD_LATCH;
              state <= ST_LATCH;
            end else begin
              idx      <= idx + 1'b1;
              pix_addr <= idx + 1'b1;
              pix_rd   <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_LATCH: begin
          if (cmd_req) begin
            cmd        <= CMD_IDLE;
            frame_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (auto_rf) begin
            bright_q <= bright;
            idx      <= '0;
            pix_addr <= '0;
            pix_rd   <= 1'b1;
            state    <= ST_FETCH;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The controller must not request while the next pixel is still in flight.
  a_no_req_in_flight: assert property (@(posedge clk) disable iff (rst)
    !(cmd_req && (state == ST_FETCH || state == ST_LOAD)));

endmodule

// File: tb/tb_ws2812_strip_scheduler.sv
// Bench: a 3-pixel strip checked through an expected-command scoreboard, and a 1-pixel strip
// driven from a table of {pixel, brightness, expected r/g/b} vectors.
module tb_ws2812_strip_scheduler;
  import ws2812_pkg::*;

  localparam int PERIOD = 240;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_auto, a_req, a_rd, a_busy, a_fd;
  logic [7:0]  a_bright, a_r, a_g, a_b;
  logic [1:0]  a_addr, a_cmd;
  logic [23:0] a_data;
  logic [23:0] a_buf [4];

  logic        b_rst, b_start, b_auto, b_req, b_rd, b_busy, b_fd;
  logic [7:0]  b_bright, b_r, b_g, b_b;
  logic [0:0]  b_addr;
  logic [1:0]  b_cmd;
  logic [23:0] b_data, b_pix;

  ws2812_strip_scheduler #(.NUM_LEDS(3)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .auto_rf(a_auto), .bright(a_bright),
    .pix_addr(a_addr), .pix_rd(a_rd), .pix_data(a_data), .r(a_r), .g(a_g), .b(a_b),
    .cmd(a_cmd), .cmd_req(a_req), .busy(a_busy), .frame_done(a_fd)
  );

  ws2812_strip_scheduler #(.NUM_LEDS(1)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .auto_rf(b_auto), .bright(b_bright),
    .pix_addr(b_addr), .pix_rd(b_rd), .pix_data(b_data), .r(b_r), .g(b_g), .b(b_b),
    .cmd(b_cmd), .cmd_req(b_req), .busy(b_busy), .frame_done(b_fd)
  );

  // Frame-buffer models: data appears one cycle after the read strobe.
  always @(posedge clk) if (a_rd) a_data <= a_buf[a_addr];
  always @(posedge clk) if (b_rd) b_data <= b_pix;

  // Controller model: one request every PERIOD cycles, only while a command is presented.
  initial begin
    int cnt;
    cnt = 0;
    a_req = 1'b0;
    b_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % PERIOD;
      a_req = (cnt == 0) && (a_cmd != CMD_IDLE) && !a_rst;
      b_req = (cnt == 0) && (b_cmd != CMD_IDLE) && !b_rst;
    end
  end

  int n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] r, g, b;
  } ev_t;
  ev_t sb[$];
  int  pops, fd_cnt;
  logic watch_busy, busy_drop, b_addr_bad;

  function automatic logic [7:0] sc(input logic [7:0] ch, input logic [7:0] br);
    int p;
    p = int'(ch) * (int'(br) + 1);
    return 8'(p >> 8);
  endfunction

  task automatic push_frame(input logic [7:0] br);
    ev_t e;
    for (int i = 0; i < 3; i++) begin
      e.cmd = CMD_SEND;
      e.r = sc(a_buf[i][23:16], br);
      e.g = sc(a_buf[i][15:8], br);
      e.b = sc(a_buf[i][7:0], br);
      sb.push_back(e);
    end
    e.cmd = CMD_LATCH;
    e.r = 8'h00;
    e.g = 8'h00;
    e.b = 8'h00;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (a_fd) fd_cnt++;
    if (watch_busy && !a_busy) busy_drop = 1'b1;
    if (b_rd && b_addr != 1'b0) b_addr_bad = 1'b1;
    if (!a_rst && a_req) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: request seen with cmd %0d, nothing expected", a_cmd);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("sb_cmd", a_cmd, e.cmd);
        if (e.cmd == CMD_SEND) begin
          chk("sb_r", a_r, e.r);
          chk("sb_g", a_g, e.g);
          chk("sb_b", a_b, e.b);
        end
      end
    end
  end

  task automatic wait_fd(input int target, input string name);
    int n;
    n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (fd_cnt < target) fail_now(name);
  endtask

  task automatic a_pulse_start();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    #1;
  endtask

  task automatic b_pulse_start();
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  br;
    logic [7:0]  r, g, b;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic found;
    tbl[0] = '{24'hFF0080, 8'd255, 8'hFF, 8'h00, 8'h80};
    tbl[1] = '{24'hFF0080, 8'd127, 8'h7F, 8'h00, 8'h40};
    tbl[2] = '{24'hFF0080, 8'd0,   8'h00, 8'h00, 8'h00};
    tbl[3] = '{24'h123456, 8'd63,  8'h04, 8'h0D, 8'h15};
    tbl[4] = '{24'hFF0080, 8'd1,   8'h01, 8'h00, 8'h01};
    tbl[5] = '{24'h00FF00, 8'd128, 8'h00, 8'h80, 8'h00};

    n_cmp = 0; n_bad = 0; pops = 0; fd_cnt = 0;
    watch_busy = 1'b0; busy_drop = 1'b0; b_addr_bad = 1'b0;
    a_rst = 1'b1; a_start = 1'b0; a_auto = 1'b0; a_bright = 8'd255;
    b_rst = 1'b1; b_start = 1'b0; b_auto = 1'b0; b_bright = 8'd255; b_pix = 24'h0;
    a_buf[0] = 24'hFF0080; a_buf[1] = 24'h00FF00; a_buf[2] = 24'h123456; a_buf[3] = 24'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd", a_cmd, CMD_IDLE);
    chk("rst_rgb", {a_r, a_g, a_b}, 24'h0);
    chk("rst_addr", a_addr, 2'd0);
    chk("rst_rd", a_rd, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_fd", a_fd, 1'b0);
    chk("rst_b_busy", b_busy, 1'b0);
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Full frame at identity brightness; start and a brightness change mid-frame are ignored.
    base = fd_cnt;
    a_bright = 8'd255;
    push_frame(8'd255);
    a_pulse_start();
    chk("t1_busy", a_busy, 1'b1);
    n = 0;
    while (a_cmd != CMD_SEND && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (a_cmd != CMD_SEND) fail_now("t1_first_send");
    a_bright = 8'd0;
    a_pulse_start();
    wait_fd(base + 1, "t1_frame_done");
    repeat (20) @(negedge clk);
    #1;
    chk("t1_fd_count", fd_cnt, base + 1);
    chk("t1_busy_end", a_busy, 1'b0);
    chk("t1_cmd_end", a_cmd, CMD_IDLE);
    chk("t1_sb_empty", sb.size(), 0);

    // Auto refresh: two frames back to back, second one picks up the new brightness.
    base = fd_cnt;
    a_bright = 8'd127;
    a_auto = 1'b1;
    push_frame(8'd127);
    push_frame(8'd255);
    a_pulse_start();
    watch_busy = 1'b1;
    a_bright = 8'd255;
    wait_fd(base + 1, "t3_frame1");
    @(negedge clk);
    #1;
    chk("t3_refetch_rd", a_rd, 1'b1);
    chk("t3_refetch_addr", a_addr, 2'd0);
    a_auto = 1'b0;
    wait_fd(base + 2, "t3_frame2");
    watch_busy = 1'b0;
    chk("t3_busy_held", busy_drop, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("t3_busy_end", a_busy, 1'b0);
    chk("t3_sb_empty", sb.size(), 0);

    // Reset in SEND with idx=1, then a clean restart from pixel 0.
    base = pops;
    push_frame(8'd255);
    a_pulse_start();
    n = 0;
    while (pops < base + 1 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pops < base + 1) fail_now("t5_first_req");
    repeat (4) @(negedge clk);
    #1;
    chk("t5_pre_addr", a_addr, 2'd1);
    chk("t5_pre_g", a_g, 8'hFF);
    chk("t5_pre_busy", a_busy, 1'b1);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_cmd", a_cmd, CMD_IDLE);
    chk("t5_rgb", {a_r, a_g, a_b}, 24'h0);
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_rd", a_rd, 1'b0);
    sb.delete();
    a_rst = 1'b0;
    base = fd_cnt;
    push_frame(8'd255);
    a_pulse_start();
    chk("t5_restart_rd", a_rd, 1'b1);
    chk("t5_restart_addr", a_addr, 2'd0);
    wait_fd(base + 1, "t5_frame_done");
    repeat (3) @(negedge clk);
    #1;
    chk("t5_fd_count", fd_cnt, base + 1);
    chk("t5_sb_empty", sb.size(), 0);

    // Single-pixel strip: scaling vectors, each a one-pixel frame.
    for (int i = 0; i < 6; i++) begin
      b_pix = tbl[i].pix;
      b_bright = tbl[i].br;
      b_pulse_start();
      found = 1'b0;
      n = 0;
      while (!found && n < 1000) begin
        @(negedge clk);
        if (b_req && b_cmd == CMD_SEND) found = 1'b1;
        n++;
      end
      if (found) begin
        chk("tbl_r", b_r, tbl[i].r);
        chk("tbl_g", b_g, tbl[i].g);
        chk("tbl_b", b_b, tbl[i].b);
        @(negedge clk);
        chk("tbl_latch", b_cmd, CMD_LATCH);
      end else begin
        fail_now("tbl_send_req");
      end
      found = 1'b0;
      n = 0;
      while (!found && n < 1000) begin
        @(negedge clk);
        if (b_fd) found = 1'b1;
        n++;
      end
      if (!found) fail_now("tbl_frame_done");
      @(negedge clk);
      chk("tbl_busy_end", b_busy, 1'b0);
    end
    chk("b_addr_range", b_addr_bad, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
